keypad_scan_ctrl: RTL
=====================

Name: keypad_scan_ctrl

Overview:
Scan controller for the 4x4 Pmod keypad on the JA connector. It drives one column low at a time, samples the four pulled-up row lines through a synchronizer, and debounces whole-matrix scans. It emits a one-hot-free 4-bit key code with press and release strobes. It sits between the JA pins and the downstream decoder/display logic, and replaces free-running ad-hoc column strobing.

Parameters:
SCAN_DIV, 100000, clk cycles each column is driven (1 ms at 100 MHz); legal range is 4 or more.
DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or release; legal range is 2 or more.

Ports:
clk  input  1  100 MHz board clock
rst_n  input  1  synchronous active-low reset
row_in  input  4  keypad rows, active-low (0 = key in driven column pressed)
col_out  output  4  keypad column drive, active-low one-hot
key_code  output  4  hex value of accepted key; held until next accepted press
key_valid  output  1  one-cycle strobe on each accepted press
key_down  output  1  level, high while an accepted key is held
key_release  output  1  one-cycle strobe on accepted release

Behaviour:
- One clock, clk. Reset is synchronous and active-low: rst_n is sampled on the rising clk edge.
- Reset values: col_out=4'b1111, key_code=0, key_valid=0, key_down=0, key_release=0. The dwell counter, column index, synchronizer, scan accumulator, candidate and stable counter all clear.
- First cycle after reset release: col_out=4'b1110 (column 0), dwell count 0.
- Column sequencing:
  - Dwell counter runs 0..SCAN_DIV-1.
  - At count SCAN_DIV-1, the 2-flop-synchronized row_in is captured into a 16-bit scan accumulator for the current column.
  - Column index then advances 0,1,2,3,0 and col_out rotates to match.
  - One full scan takes 4*SCAN_DIV cycles. The synchronizer delay is covered because SCAN_DIV >= 4.
- Key map (row r, column c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Scan evaluation happens in the cycle after the column-3 capture. The scan result is one of:
  - NONE: no bits low.
  - SINGLE(code): exactly one bit low.
  - MULTI: two or more bits low.
- Debounce:
  - MULTI clears the stable counter and leaves the candidate, key_down and key_code unchanged. No strobes are issued.
  - If the result equals the candidate, the stable counter increments, saturating at DEBOUNCE_SCANS-1. Otherwise the candidate becomes the new result and the counter is set to 0.
  - Acceptance occurs when the counter reaches DEBOUNCE_SCANS-1 on this evaluation, i.e. the result has been identical for DEBOUNCE_SCANS consecutive scans.
- State machine, states IDLE and PRESSED:
  - IDLE, accepted SINGLE(k): key_code<=k, key_valid pulses, key_down<=1, go to PRESSED.
  - PRESSED, accepted NONE: key_release pulses, key_down<=0, go to IDLE. key_code is retained.
  - PRESSED, accepted SINGLE(k) with k different from key_code: key_code<=k, key_valid pulses, no key_release, stay in PRESSED.
  - PRESSED, accepted SINGLE(k) with k equal to key_code: no action.
  - Saturated repeats never re-pulse.
- Strobe timing: strobes are registered, asserted in the cycle after the evaluation cycle, and last exactly one cycle. key_valid and key_release are never high together.
- Reset mid-scan or mid-press behaves as full reset. Detection restarts from column 0 and needs DEBOUNCE_SCANS fresh scans.

Test Plan:
Bench setup: SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-cycle scan). The keypad model drives row_in[r]=0 when key (r,c) is pressed and col_out[c]=0.
- Hold '5' (r1,c1) from reset release -> after the 3rd complete scan: single key_valid pulse, key_code=4'h5, key_down=1; col_out cycles 1110,1101,1011,0111 every 4 cycles.
- Toggle '5' every 7 cycles for 60 cycles, then hold -> zero strobes during bouncing; exactly one key_valid with key_code=5 after 3 stable scans.
- Hold '1' and '2' together -> no key_valid, key_down stays 0. Release '2' -> key_valid with key_code=1 after 3 scans.
- Release '5' from PRESSED -> key_release pulse after 3 empty scans; key_down=0; key_code stays 5.
- Roll from '5' to 'A' (r0,c3) with no empty scan -> key_valid with key_code=4'hA, no key_release, key_down stays 1.
- Assert rst_n=0 for 2 cycles while '5' is held -> all outputs 0, col_out=1111. After release, key_valid occurs again only after 3 complete scans.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// Column-strobing scan controller for a 4x4 active-low keypad.
// Captures synchronized rows per column, debounces whole scans, and reports press/release events.
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | no accepted key held
// PRESSED | an accepted key is held, key_code reports it
module keypad_scan_ctrl #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output logic       key_release
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [DW-1:0] DWELL_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(DEBOUNCE_SCANS - 1);
    localparam logic [SW-1:0] STABLE_PRE  = SW'(DEBOUNCE_SCANS - 2);

    typedef enum logic {IDLE, PRESSED} state_t;
    typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_t;

    state_t          state, state_next;
    logic            running;
    logic [DW-1:0]   dwell_cnt;
    logic [1:0]      col_idx;
    logic [1:0]      col_nxt;
    logic [3:0]      row_meta, row_sync;
    logic [15:0]     scan_acc;
    logic            eval_pend;
    logic            cand_single;
    logic [3:0]      cand_code;
    logic [SW-1:0]   stable_cnt;

    res_t            res_kind;
    logic [3:0]      res_code;
    logic [4:0]      low_cnt;
    logic [3:0]      low_idx;
    logic            res_match;
    logic            accept;

    logic [3:0]      code_next;
    logic            valid_next, release_next, down_next;

    assign col_nxt = col_idx + 2'd1;

    // Column dwell, row synchronizer and per-column capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running   <= 1'b0;
            dwell_cnt <= '0;
            col_idx   <= 2'd0;
            col_out   <= 4'b1111;
            row_meta  <= 4'hF;
            row_sync  <= 4'hF;
            scan_acc  <= 16'hFFFF;
            eval_pend <= 1'b0;
        end else begin
            row_meta  <= row_in;
            row_sync  <= row_meta;
            eval_pend <= 1'b0;
            if (!running) begin
                running   <= 1'b1;
                dwell_cnt <= '0;
                col_idx   <= 2'd0;
                col_out   <= 4'b1110;
            end else if (dwell_cnt == DWELL_LAST) begin
                dwell_cnt                   <= '0;
                col_idx                     <= col_nxt;
                col_out                     <= ~(4'b0001 << col_nxt);
                scan_acc[{col_idx, 2'b00} +: 4] <= row_sync;
                eval_pend                   <= (col_idx == 2'd3);
            end else begin
                dwell_cnt <= dwell_cnt + DW'(1);
            end
        end
    end

    // Scan accumulator bit index is {column, row}.
    always_comb begin
        low_cnt = 5'd0;
        low_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (!scan_acc[i]) begin
                low_cnt = low_cnt + 5'd1;
                low_idx = 4'(i);
            end
        end
    end

    always_comb begin
        res_code = 4'h0;
        case ({low_idx[1:0], low_idx[3:2]})
            4'b00_00: res_code = 4'h1;
            4'b00_01: res_code = 4'h2;
            4'b00_10: res_code = 4'h3;
            4'b00_11: res_code = 4'hA;
            4'b01_00: res_code = 4'h4;
            4'b01_01: res_code = 4'h5;
            4'b01_10: res_code = 4'h6;
            4'b01_11: res_code = 4'hB;
            4'b10_00: res_code = 4'h7;
            4'b10_01: res_code = 4'h8;
            4'b10_10: res_code = 4'h9;
            4'b10_11: res_code = 4'hC;
            4'b11_00: res_code = 4'h0;
            4'b11_01: res_code = 4'hF;
            4'b11_10: res_code = 4'hE;
            4'b11_11: res_code = 4'hD;
            default:  res_code = 4'h0;
        endcase
    end

    always_comb begin
        res_kind = RES_MULTI;
        if (low_cnt == 5'd0)      res_kind = RES_NONE;
        else if (low_cnt == 5'd1) res_kind = RES_SINGLE;
        res_match = ((res_kind == RES_NONE) && !cand_single) ||
                    ((res_kind == RES_SINGLE) && cand_single && (cand_code == res_code));
        // Acceptance fires only on the transition into saturation, never on repeats.
        accept = eval_pend && (res_kind != RES_MULTI) && res_match && (stable_cnt == STABLE_PRE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand_single <= 1'b0;
            cand_code   <= 4'h0;
            stable_cnt  <= '0;
        end else if (eval_pend) begin
            if (res_kind == RES_MULTI) begin
                stable_cnt <= '0;
            end else if (res_match) begin
                if (stable_cnt != STABLE_LAST) stable_cnt <= stable_cnt + SW'(1);
            end else begin
                cand_single <= (res_kind == RES_SINGLE);
                cand_code   <= res_code;
                stable_cnt  <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            key_code    <= 4'h0;
            key_valid   <= 1'b0;
            key_down    <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_next;
            key_code    <= code_next;
            key_valid   <= valid_next;
            key_down    <= down_next;
            key_release <= release_next;
        end
    end

    always_comb begin
        state_next   = state;
        code_next    = key_code;
        valid_next   = 1'b0;
        release_next = 1'b0;
        down_next    = key_down;
        case (state)
            IDLE: begin
                if (accept && (res_kind == RES_SINGLE)) begin
                    code_next  = res_code;
                    valid_next = 1'b1;
                    down_next  = 1'b1;
                    state_next = PRESSED;
                end
            end
            PRESSED: begin
                if (accept && (res_kind == RES_NONE)) begin
                    release_next = 1'b1;
                    down_next    = 1'b0;
                    state_next   = IDLE;
                end else if (accept && (res_kind == RES_SINGLE) && (res_code != key_code)) begin
                    code_next  = res_code;
                    valid_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
